// File: rtl/lcd_spi_pkg.sv
// Shared definitions for the 9-bit LCD SPI link: ST7789 command codes,
// panel resolution defaults and the receiver command-state encoding.
package lcd_spi_pkg;

   localparam int LCD_H_RES = 240;
   localparam int LCD_V_RES = 240;

   localparam logic [7:0] CMD_CASET = 8'h2A;
   localparam logic [7:0] CMD_RASET = 8'h2B;
   localparam logic [7:0] CMD_RAMWR = 8'h2C;

   typedef enum logic [2:0] {
      IDLE,
      CASET,
      RASET,
      RAMWR,
      SKIP
   } lcd_state_t;

endpackage

// File: rtl/lcd_spi_deser.sv
// Byte deserialiser for the LCD SPI link.
// It resynchronises the pins, detects sclk rises and shifts mosi in MSB first.
// Each complete byte is reported with its dc bit, and a byte cut short by a
// chip-select release is reported as a fragment error.
module lcd_spi_deser #(
   parameter int SYNC_STAGES = 2
) (
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic       i_cs,
   input  logic       i_dc,
   input  logic       i_sclk,
   input  logic       i_mosi,
   output logic       o_byteValid,
   output logic [7:0] o_byteData,
   output logic       o_byteDc,
   output logic       o_fragErr
);

   logic [SYNC_STAGES-1:0] r_csSync;
   logic [SYNC_STAGES-1:0] r_dcSync;
   logic [SYNC_STAGES-1:0] r_sclkSync;
   logic [SYNC_STAGES-1:0] r_mosiSync;
   logic                   r_sclkPrev;
   logic                   r_csPrev;
   logic [7:0]             r_sr;
   logic [2:0]             r_bitCnt;
   logic                   r_full;
   logic                   r_dcLat;

   logic w_cs;
   logic w_dc;
   logic w_sclk;
   logic w_mosi;
   logic w_sclkRise;
   logic w_csRise;
   logic w_shift;
   logic w_lastBit;

   assign w_cs       = r_csSync[SYNC_STAGES-1];
   assign w_dc       = r_dcSync[SYNC_STAGES-1];
   assign w_sclk     = r_sclkSync[SYNC_STAGES-1];
   assign w_mosi     = r_mosiSync[SYNC_STAGES-1];
   assign w_sclkRise = w_sclk & ~r_sclkPrev;
   assign w_csRise   = w_cs & ~r_csPrev;
   // A bit is still accepted in the cycle cs rises, so a byte whose last
   // edge coincides with the cs release completes cleanly.
   assign w_shift    = w_sclkRise & (~w_cs | ~r_csPrev);
   assign w_lastBit  = w_shift & (r_bitCnt == 3'd7);

   // Bring the asynchronous pins into the clock domain; cs idles high so the
   // chain resets to 1 and no spurious cs edge appears after reset.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_csSync   <= '1;
         r_dcSync   <= '0;
         r_sclkSync <= '0;
         r_mosiSync <= '0;
         r_sclkPrev <= 1'b0;
         r_csPrev   <= 1'b1;
      end else begin
         r_csSync   <= {r_csSync[SYNC_STAGES-2:0], i_cs};
         r_dcSync   <= {r_dcSync[SYNC_STAGES-2:0], i_dc};
         r_sclkSync <= {r_sclkSync[SYNC_STAGES-2:0], i_sclk};
         r_mosiSync <= {r_mosiSync[SYNC_STAGES-2:0], i_mosi};
         r_sclkPrev <= w_sclk;
         r_csPrev   <= w_cs;
      end
   end

   // Shift register and bit counter; a cs rise discards any partial byte and
   // flags it, and a completed byte is presented one cycle after its last bit.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_sr        <= '0;
         r_bitCnt    <= '0;
         r_full      <= 1'b0;
         r_dcLat     <= 1'b0;
         o_fragErr   <= 1'b0;
         o_byteValid <= 1'b0;
         o_byteData  <= '0;
         o_byteDc    <= 1'b0;
      end else begin
         r_full <= 1'b0;
         if (w_shift) begin
            r_sr <= {r_sr[6:0], w_mosi};
            if (w_lastBit) begin
               r_full   <= 1'b1;
               r_dcLat  <= w_dc;
               r_bitCnt <= '0;
            end else begin
               r_bitCnt <= r_bitCnt + 3'd1;
            end
         end
         if (w_csRise && !w_lastBit) begin
            r_bitCnt <= '0;
         end
         o_fragErr   <= w_csRise & ~w_lastBit & ((r_bitCnt != 3'd0) | w_shift);
         o_byteValid <= r_full;
         if (r_full) begin
            o_byteData <= r_sr;
            o_byteDc   <= r_dcLat;
         end
      end
   end

endmodule

// File: rtl/lcd_spi_rx.sv
// Receiver for the ST7789 LCD SPI stream.
// It decodes CASET/RASET/RAMWR and emits every RGB565 pixel with its
// coordinate, so a mirror frame buffer or checker can follow the panel.
module lcd_spi_rx
   import lcd_spi_pkg::*;
#(
   parameter int H_RES       = LCD_H_RES,
   parameter int V_RES       = LCD_V_RES,
   parameter int SYNC_STAGES = 2
) (
   input  logic        sys_clk_50MHz,
   input  logic        sys_rst_n,
   input  logic        lcd_cs,
   input  logic        lcd_dc,
   input  logic        lcd_sclk,
   input  logic        lcd_mosi,
   output logic        byte_valid,
   output logic [7:0]  byte_data,
   output logic        byte_dc,
   output logic        pix_valid,
   output logic [8:0]  pix_x,
   output logic [8:0]  pix_y,
   output logic [15:0] pix_data,
   output logic        frame_done,
   output logic        err
);

   localparam logic [8:0] X_MAX = 9'(H_RES - 1);
   localparam logic [8:0] Y_MAX = 9'(V_RES - 1);

   logic       w_byteValid;
   logic [7:0] w_byteData;
   logic       w_byteDc;
   logic       w_fragErr;
   logic [8:0] w_endVal;
   logic [8:0] w_limit;

   lcd_state_t  r_state, w_stateNext;
   logic [1:0]  r_argCnt, w_argCntNext;
   logic [8:0]  r_argStart, w_argStartNext;
   logic        r_argEndHi, w_argEndHiNext;
   logic [8:0]  r_xs, r_xe, r_ys, r_ye;
   logic [8:0]  w_xsNext, w_xeNext, w_ysNext, w_yeNext;
   logic [8:0]  r_x, r_y, w_xNext, w_yNext;
   logic        r_half, w_halfNext;
   logic [7:0]  r_hi, w_hiNext;
   logic        w_pixValidNext;
   logic [8:0]  w_pixXNext, w_pixYNext;
   logic [15:0] w_pixDataNext;
   logic        w_frameNext;
   logic        w_errNext;

   lcd_spi_deser #(
      .SYNC_STAGES(SYNC_STAGES)
   ) u_deser (
      .i_clk      (sys_clk_50MHz),
      .i_rst_n    (sys_rst_n),
      .i_cs       (lcd_cs),
      .i_dc       (lcd_dc),
      .i_sclk     (lcd_sclk),
      .i_mosi     (lcd_mosi),
      .o_byteValid(w_byteValid),
      .o_byteData (w_byteData),
      .o_byteDc   (w_byteDc),
      .o_fragErr  (w_fragErr)
   );

   assign byte_valid = w_byteValid;
   assign byte_data  = w_byteData;
   assign byte_dc    = w_byteDc;
   assign w_endVal   = {r_argEndHi, w_byteData};
   assign w_limit    = (r_state == RASET) ? Y_MAX : X_MAX;

   // Command state, window, write pointer and registered pixel outputs.
   always_ff @(posedge sys_clk_50MHz or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         r_state    <= IDLE;
         r_argCnt   <= '0;
         r_argStart <= '0;
         r_argEndHi <= 1'b0;
         r_xs       <= '0;
         r_xe       <= X_MAX;
         r_ys       <= '0;
         r_ye       <= Y_MAX;
         r_x        <= '0;
         r_y        <= '0;
         r_half     <= 1'b0;
         r_hi       <= '0;
         pix_valid  <= 1'b0;
         pix_x      <= '0;
         pix_y      <= '0;
         pix_data   <= '0;
         frame_done <= 1'b0;
         err        <= 1'b0;
      end else begin
         r_state    <= w_stateNext;
         r_argCnt   <= w_argCntNext;
         r_argStart <= w_argStartNext;
         r_argEndHi <= w_argEndHiNext;
         r_xs       <= w_xsNext;
         r_xe       <= w_xeNext;
         r_ys       <= w_ysNext;
         r_ye       <= w_yeNext;
         r_x        <= w_xNext;
         r_y        <= w_yNext;
         r_half     <= w_halfNext;
         r_hi       <= w_hiNext;
         pix_valid  <= w_pixValidNext;
         pix_x      <= w_pixXNext;
         pix_y      <= w_pixYNext;
         pix_data   <= w_pixDataNext;
         frame_done <= w_frameNext;
         err        <= w_errNext;
      end
   end

   // Decode each received byte: commands always restart the state machine,
   // data bytes are window arguments or pixel halves depending on the state.
   always_comb begin
      w_stateNext    = r_state;
      w_argCntNext   = r_argCnt;
      w_argStartNext = r_argStart;
      w_argEndHiNext = r_argEndHi;
      w_xsNext       = r_xs;
      w_xeNext       = r_xe;
      w_ysNext       = r_ys;
      w_yeNext       = r_ye;
      w_xNext        = r_x;
      w_yNext        = r_y;
      w_halfNext     = r_half;
      w_hiNext       = r_hi;
      w_pixValidNext = 1'b0;
      w_pixXNext     = pix_x;
      w_pixYNext     = pix_y;
      w_pixDataNext  = pix_data;
      w_frameNext    = 1'b0;
      w_errNext      = w_fragErr;

      if (w_byteValid) begin
         if (!w_byteDc) begin
            if (r_state == RAMWR && r_half) begin
               w_errNext = 1'b1;
            end
            w_halfNext   = 1'b0;
            w_argCntNext = '0;
            case (w_byteData)
               CMD_CASET: w_stateNext = CASET;
               CMD_RASET: w_stateNext = RASET;
               CMD_RAMWR: begin
                  w_stateNext = RAMWR;
                  w_xNext     = r_xs;
                  w_yNext     = r_ys;
               end
               default:   w_stateNext = SKIP;
            endcase
         end else begin
            case (r_state)
               CASET, RASET: begin
                  w_argCntNext = r_argCnt + 2'd1;
                  case (r_argCnt)
                     2'd0: w_argStartNext[8]   = w_byteData[0];
                     2'd1: w_argStartNext[7:0] = w_byteData;
                     2'd2: w_argEndHiNext      = w_byteData[0];
                     default: begin
                        w_stateNext = IDLE;
                        if (r_argStart > w_endVal || w_endVal > w_limit) begin
                           w_errNext = 1'b1;
                        end else if (r_state == CASET) begin
                           w_xsNext = r_argStart;
                           w_xeNext = w_endVal;
                        end else begin
                           w_ysNext = r_argStart;
                           w_yeNext = w_endVal;
                        end
                     end
                  endcase
               end
               RAMWR: begin
                  if (!r_half) begin
                     w_hiNext   = w_byteData;
                     w_halfNext = 1'b1;
                  end else begin
                     w_halfNext     = 1'b0;
                     w_pixValidNext = 1'b1;
                     w_pixXNext     = r_x;
                     w_pixYNext     = r_y;
                     w_pixDataNext  = {r_hi, w_byteData};
                     if (r_x < r_xe) begin
                        w_xNext = r_x + 9'd1;
                     end else begin
                        w_xNext = r_xs;
                        if (r_y < r_ye) begin
                           w_yNext = r_y + 9'd1;
                        end else begin
                           w_yNext     = r_ys;
                           w_frameNext = 1'b1;
                        end
                     end
                  end
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_lcd_spi_rx.sv
// Directed bench for lcd_spi_rx: drives the 9-bit SPI stream at clk/4 and
// checks bytes, window commits, pixel coordinates, errors and reset.
module tb_lcd_spi_rx;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        lcd_cs = 1'b1;
   logic        lcd_dc = 1'b0;
   logic        lcd_sclk = 1'b0;
   logic        lcd_mosi = 1'b0;
   logic        byte_valid;
   logic [7:0]  byte_data;
   logic        byte_dc;
   logic        pix_valid;
   logic [8:0]  pix_x;
   logic [8:0]  pix_y;
   logic [15:0] pix_data;
   logic        frame_done;
   logic        err;

   int errors = 0;
   int checks = 0;

   int byteCnt = 0;
   int pixCnt = 0;
   int errCnt = 0;
   int frameCnt = 0;
   logic [8:0]  byteLog [64];
   logic [34:0] pixLog [64];

   lcd_spi_rx dut (
      .sys_clk_50MHz(clk),
      .sys_rst_n    (rst_n),
      .lcd_cs       (lcd_cs),
      .lcd_dc       (lcd_dc),
      .lcd_sclk     (lcd_sclk),
      .lcd_mosi     (lcd_mosi),
      .byte_valid   (byte_valid),
      .byte_data    (byte_data),
      .byte_dc      (byte_dc),
      .pix_valid    (pix_valid),
      .pix_x        (pix_x),
      .pix_y        (pix_y),
      .pix_data     (pix_data),
      .frame_done   (frame_done),
      .err          (err)
   );

   // Free-running system clock.
   always #5 clk = ~clk;

   // Record every output pulse on the falling edge, away from the active edge.
   always @(negedge clk) begin
      if (byte_valid) begin
         if (byteCnt < 64) byteLog[byteCnt] = {byte_dc, byte_data};
         byteCnt = byteCnt + 1;
      end
      if (pix_valid) begin
         if (pixCnt < 64) pixLog[pixCnt] = {frame_done, pix_x, pix_y, pix_data};
         pixCnt = pixCnt + 1;
      end
      if (err) errCnt = errCnt + 1;
      if (frame_done) frameCnt = frameCnt + 1;
   end

   // Guarantee termination even if the DUT stalls the sequence.
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      checks = checks + 1;
      assert (observed === expected)
      else begin
         errors = errors + 1;
         $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // Send nBits of b MSB first at sclk = clk/4; lat returns the number of
   // clocks from the 8th sclk rise to byte_valid (0 if not seen).
   task automatic applyStimulus(input logic dc, input logic [7:0] b, input int nBits, output int lat);
      lcd_cs = 1'b0;
      lcd_dc = dc;
      lat = 0;
      for (int i = 0; i < nBits; i++) begin
         lcd_mosi = b[7-i];
         tick(2);
         lcd_sclk = 1'b1;
         if (i == 7) begin
            for (int k = 1; k <= 6; k++) begin
               @(posedge clk);
               #1;
               if (byte_valid && lat == 0) lat = k;
            end
         end else begin
            tick(2);
         end
         lcd_sclk = 1'b0;
      end
      tick(2);
   endtask

   task automatic sendByte(input logic dc, input logic [7:0] b);
      int unusedLat;
      applyStimulus(dc, b, 8, unusedLat);
   endtask

   task automatic doReset();
      rst_n = 1'b0;
      lcd_cs = 1'b1;
      lcd_sclk = 1'b0;
      lcd_mosi = 1'b0;
      lcd_dc = 1'b0;
      tick(3);
      rst_n = 1'b1;
      tick(4);
   endtask

   initial begin
      int lat;
      int b0, p0, e0, f0;

      // Reset state
      tick(3);
      checkOutput("reset_outputs",
                  {byte_valid, byte_data, byte_dc, pix_valid, pix_x, pix_y, pix_data, frame_done, err}, 64'd0);
      rst_n = 1'b1;
      tick(4);

      // Byte and latency check: CASET 10..19
      $display("[TB] byte/latency");
      b0 = byteCnt; e0 = errCnt;
      applyStimulus(1'b0, 8'h2A, 8, lat);
      checkOutput("latency", 64'(lat), 64'd4);
      sendByte(1'b1, 8'h00);
      sendByte(1'b1, 8'h0A);
      sendByte(1'b1, 8'h00);
      sendByte(1'b1, 8'h13);
      tick(4);
      checkOutput("byte_count", 64'(byteCnt - b0), 64'd5);
      checkOutput("byte0", 64'(byteLog[b0]), 64'h02A);
      checkOutput("byte4", 64'(byteLog[b0+4]), 64'h113);
      checkOutput("caset_xs", 64'(dut.r_xs), 64'd10);
      checkOutput("caset_xe", 64'(dut.r_xe), 64'd19);
      checkOutput("caset_err", 64'(errCnt - e0), 64'd0);

      // Pixel walk over x 10..11, y 5..6
      $display("[TB] pixel walk");
      p0 = pixCnt; f0 = frameCnt;
      sendByte(1'b0, 8'h2A);
      sendByte(1'b1, 8'h00); sendByte(1'b1, 8'h0A); sendByte(1'b1, 8'h00); sendByte(1'b1, 8'h0B);
      sendByte(1'b0, 8'h2B);
      sendByte(1'b1, 8'h00); sendByte(1'b1, 8'h05); sendByte(1'b1, 8'h00); sendByte(1'b1, 8'h06);
      sendByte(1'b0, 8'h2C);
      sendByte(1'b1, 8'hF8); sendByte(1'b1, 8'h00);
      sendByte(1'b1, 8'h07); sendByte(1'b1, 8'hE0);
      sendByte(1'b1, 8'h00); sendByte(1'b1, 8'h1F);
      sendByte(1'b1, 8'hFF); sendByte(1'b1, 8'hFF);
      sendByte(1'b1, 8'h12); sendByte(1'b1, 8'h34);
      tick(4);
      checkOutput("walk_count", 64'(pixCnt - p0), 64'd5);
      checkOutput("pix0", 64'(pixLog[p0]),   64'({1'b0, 9'd10, 9'd5, 16'hF800}));
      checkOutput("pix1", 64'(pixLog[p0+1]), 64'({1'b0, 9'd11, 9'd5, 16'h07E0}));
      checkOutput("pix2", 64'(pixLog[p0+2]), 64'({1'b0, 9'd10, 9'd6, 16'h001F}));
      checkOutput("pix3", 64'(pixLog[p0+3]), 64'({1'b1, 9'd11, 9'd6, 16'hFFFF}));
      checkOutput("pix4_wrap", 64'(pixLog[p0+4]), 64'({1'b0, 9'd10, 9'd5, 16'h1234}));
      checkOutput("frame_count", 64'(frameCnt - f0), 64'd1);

      // Partial-pixel abort
      $display("[TB] partial pixel");
      doReset();
      p0 = pixCnt; e0 = errCnt;
      sendByte(1'b0, 8'h2C);
      sendByte(1'b1, 8'h11);
      sendByte(1'b0, 8'h00);
      tick(4);
      checkOutput("partial_err", 64'(errCnt - e0), 64'd1);
      checkOutput("partial_nopix", 64'(pixCnt - p0), 64'd0);
      sendByte(1'b0, 8'h2C);
      sendByte(1'b1, 8'hAB);
      sendByte(1'b1, 8'hCD);
      tick(4);
      checkOutput("after_partial", 64'(pixLog[p0]), 64'({1'b0, 9'd0, 9'd0, 16'hABCD}));

      // Fragmented byte
      $display("[TB] fragment");
      doReset();
      b0 = byteCnt; e0 = errCnt;
      applyStimulus(1'b1, 8'hA5, 5, lat);
      lcd_cs = 1'b1;
      tick(8);
      checkOutput("frag_err", 64'(errCnt - e0), 64'd1);
      checkOutput("frag_nobyte", 64'(byteCnt - b0), 64'd0);
      sendByte(1'b1, 8'h5A);
      tick(4);
      checkOutput("frag_next", 64'(byteLog[b0]), 64'h15A);

      // Bad windows and the exact column/row limit
      $display("[TB] bad window");
      doReset();
      e0 = errCnt; p0 = pixCnt;
      sendByte(1'b0, 8'h2A);
      sendByte(1'b1, 8'h00); sendByte(1'b1, 8'hF0); sendByte(1'b1, 8'h00); sendByte(1'b1, 8'h05);
      tick(4);
      checkOutput("bad_start_err", 64'(errCnt - e0), 64'd1);
      checkOutput("bad_window", 64'({dut.r_xs, dut.r_xe}), 64'({9'd0, 9'd239}));
      sendByte(1'b0, 8'h2A);
      sendByte(1'b1, 8'h00); sendByte(1'b1, 8'h00); sendByte(1'b1, 8'h00); sendByte(1'b1, 8'hF0);
      tick(4);
      checkOutput("bad_end_err", 64'(errCnt - e0), 64'd2);
      sendByte(1'b0, 8'h2B);
      sendByte(1'b1, 8'h00); sendByte(1'b1, 8'h00); sendByte(1'b1, 8'h00); sendByte(1'b1, 8'hEF);
      tick(4);
      checkOutput("limit_ok", 64'(errCnt - e0), 64'd2);
      sendByte(1'b0, 8'h2C);
      sendByte(1'b1, 8'h12);
      sendByte(1'b1, 8'h34);
      tick(4);
      checkOutput("bad_win_pix", 64'(pixLog[p0]), 64'({1'b0, 9'd0, 9'd0, 16'h1234}));

      // Reset in the middle of the third pixel
      $display("[TB] reset mid-frame");
      doReset();
      sendByte(1'b0, 8'h2C);
      sendByte(1'b1, 8'hAA); sendByte(1'b1, 8'hBB);
      sendByte(1'b1, 8'hCC); sendByte(1'b1, 8'hDD);
      sendByte(1'b1, 8'h55);
      applyStimulus(1'b1, 8'h66, 4, lat);
      checkOutput("pre_rst_byte", 64'(byte_data), 64'h55);
      checkOutput("pre_rst_pix", 64'({pix_x, pix_data}), 64'({9'd1, 16'hCCDD}));
      rst_n = 1'b0;
      #1;
      checkOutput("mid_rst_outputs",
                  {byte_valid, byte_data, byte_dc, pix_valid, pix_x, pix_y, pix_data, frame_done, err}, 64'd0);
      lcd_cs = 1'b1;
      lcd_sclk = 1'b0;
      tick(3);
      rst_n = 1'b1;
      tick(4);
      b0 = byteCnt; p0 = pixCnt;
      sendByte(1'b1, 8'h77);
      sendByte(1'b1, 8'h88);
      tick(4);
      checkOutput("post_rst_nopix", 64'(pixCnt - p0), 64'd0);
      checkOutput("post_rst_bytes", 64'(byteCnt - b0), 64'd2);
      checkOutput("post_rst_fresh", 64'(byteLog[b0]), 64'h177);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
